// File: rtl/rom_lookup_pkg.sv
// Shared constants and helpers for the ROM lookup pipeline.
// The optional statistics counters are enabled by ROM_LOOKUP_STATS_EN.
package rom_lookup_pkg;

    localparam int ROM_ADDR_WIDTH    = 5;
    localparam int DEFAULT_BUS_WIDTH = 32;
    localparam int DEFAULT_TAG_WIDTH = 4;
    localparam int FIFO_DEPTH        = 2;

    typedef logic [15:0] stat_cnt_t;

    function automatic stat_cnt_t satInc(input stat_cnt_t value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rom_lookup_fifo2.sv
// Two-entry FIFO holding returned ROM words with their tags.
// Pointers wrap modulo 2; storage is deliberately left unreset.
module rom_lookup_fifo2
    import rom_lookup_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // A simultaneous write and read leaves the occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ wr_en;
        rd_ptr_d = rd_ptr_q ^ rd_en;
        count_d  = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 2'd1;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/rom_lookup_pipe.sv
// Pipelined lookup front-end for a registered LUT ROM with in-order tagged responses.
// Defining ROM_LOOKUP_STATS_EN adds saturating accept/stall counters.
module rom_lookup_pipe
    import rom_lookup_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ROM_ADDR_WIDTH-1:0] req_addr,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [BUS_WIDTH-1:0]      rom_dout,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BUS_WIDTH-1:0]      rsp_data,
`ifdef ROM_LOOKUP_STATS_EN
    output logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic [15:0]               stat_req_cnt,
    output logic [15:0]               stat_stall_cnt
`else
    output logic [TAG_WIDTH-1:0]      rsp_tag
`endif
);

    localparam int ENTRY_WIDTH = BUS_WIDTH + TAG_WIDTH;

    logic                   accept;
    logic                   pop;
    logic                   inflight_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [1:0]             fifo_count;
    logic [ENTRY_WIDTH-1:0] fifo_rd_data;
    logic [2:0]             occupancy;

    assign rom_addr = req_addr;
    assign accept   = req_valid & req_ready;
    assign pop      = rsp_valid & rsp_ready;

    // Count the lookup still inside the ROM so the FIFO always has room when it lands.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign req_ready = (occupancy < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q <= req_tag;
        end
    end

    // A reset in the cycle the ROM word arrives clears the FIFO, dropping that word.
    rom_lookup_fifo2 #(
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data ({rom_dout, tag_q}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    assign rsp_valid           = (fifo_count != 2'd0);
    assign {rsp_data, rsp_tag} = fifo_rd_data;

`ifdef ROM_LOOKUP_STATS_EN
    stat_cnt_t stat_req_cnt_q, stat_req_cnt_d;
    stat_cnt_t stat_stall_cnt_q, stat_stall_cnt_d;

    always_comb begin
        stat_req_cnt_d   = stat_req_cnt_q;
        stat_stall_cnt_d = stat_stall_cnt_q;
        if (accept) begin
            stat_req_cnt_d = satInc(stat_req_cnt_q);
        end
        if (req_valid && !req_ready) begin
            stat_stall_cnt_d = satInc(stat_stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_cnt_q   <= 16'd0;
            stat_stall_cnt_q <= 16'd0;
        end else begin
            stat_req_cnt_q   <= stat_req_cnt_d;
            stat_stall_cnt_q <= stat_stall_cnt_d;
        end
    end

    assign stat_req_cnt   = stat_req_cnt_q;
    assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule

// File: doc/rom_lookup_pipe.md
ROM_LOOKUP_PIPE -- requirements
Module: rom_lookup_pipe

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: width of the ROM data word and of rsp_data.
REQ-002 SHALL have parameter TAG_WIDTH, default 4: width of the sideband tag carried with each lookup.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: lookup request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_addr, input, 5: ROM index to look up.
REQ-008 SHALL have port req_tag, input, TAG_WIDTH: sideband returned unchanged with the result.
REQ-009 SHALL have port rom_addr, output, 5: address to the downstream LUT ROM.
REQ-010 SHALL have port rom_dout, input, BUS_WIDTH: registered ROM data, valid one cycle after rom_addr.
REQ-011 SHALL have port rsp_valid, output, 1: result present.
REQ-012 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port rsp_data, output, BUS_WIDTH: ROM word for the oldest outstanding lookup.
REQ-014 SHALL have port rsp_tag, output, TAG_WIDTH: tag of that lookup.

Function
REQ-015 SHALL drive rom_addr = req_addr combinationally every cycle.
REQ-016 SHALL define accept = req_valid & req_ready and pop = rsp_valid & rsp_ready.
REQ-017 SHALL register an in-flight flag (inflight <= accept) and its tag (tag_q <= req_tag when accept).
REQ-018 SHALL, in the cycle after an accept, write {rom_dout, tag_q} into a 2-entry FIFO.
REQ-019 SHALL drive req_ready = (fifo_count + inflight - pop) < 2, so the FIFO can never overflow.
REQ-020 SHALL drive rsp_valid = (fifo_count != 0), with rsp_data and rsp_tag taken from the FIFO head.
REQ-021 SHALL hold rsp_data and rsp_tag stable while rsp_valid=1 and rsp_ready=0.
REQ-022 SHALL return results in request order, with latency from accept to first rsp_valid of exactly 2 cycles.
REQ-023 SHALL sustain 1 lookup per cycle when rsp_ready is held at 1.
REQ-024 SHALL handle a FIFO write and a pop in the same cycle as simultaneous, leaving fifo_count unchanged.
REQ-025 SHALL wrap the FIFO pointers modulo 2.
REQ-026 SHALL accept req_valid=1 with req_ready=0 without error; the request is held by the requester.

Reset
REQ-027 SHALL, on rst=1, clear inflight, fifo_count and the pointers, giving rsp_valid=0 and req_ready=1 after reset.
REQ-028 SHALL, when rst is asserted mid-operation, discard in-flight and buffered lookups and ignore the rom_dout that arrives the following cycle.
REQ-029 SHALL leave the data and tag storage unreset.

Configuration
REQ-030 SHALL, when macro ROM_LOOKUP_STATS_EN is defined, add outputs stat_req_cnt[15:0] and stat_stall_cnt[15:0].
- stat_req_cnt counts accepts; stat_stall_cnt counts cycles with req_valid & !req_ready.
- Both saturate at 16'hFFFF and are cleared by rst.
REQ-031 SHALL, when ROM_LOOKUP_STATS_EN is not defined, have neither these ports nor the counter logic.

Structure
REQ-032 SHALL take the address width constant (5) and the default BUS_WIDTH/TAG_WIDTH values from shared package rom_lookup_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module rom_lookup_fifo2, parameterised by its data width.

Verification
REQ-034 SHALL cover single lookup: req_addr=5'd3, tag=4'hA accepted at cycle 0 -> rsp_valid at cycle 2 with rsp_data equal to the ROM word at index 3 and rsp_tag=4'hA.
REQ-035 SHALL cover streaming: addresses 0..31 back-to-back with rsp_ready=1 -> 32 responses on consecutive cycles, in order, req_ready never low.
REQ-036 SHALL cover backpressure: rsp_ready=0 with continuous requests -> exactly 2 accepts, then req_ready=0 and data held; releasing rsp_ready drains both in order with no loss.
REQ-037 SHALL cover simultaneous events: fifo_count=1 with a pop in the same cycle as a write arrives -> count stays 1 and req_ready=1.
REQ-038 SHALL cover reset mid-flight: rst pulsed the cycle after an accept -> no response ever appears, and rsp_valid=0, req_ready=1 on the first cycle after rst deasserts.
REQ-039 SHALL cover statistics with ROM_LOOKUP_STATS_EN: 10 accepts and 3 stalled cycles -> stat_req_cnt=10 and stat_stall_cnt=3.
